// File: rtl/qs_fifo_pkg.sv
// Shared helpers and types for the qs FIFO family.
// Width functions keep count and pointer sizing consistent across instances.
package qs_fifo_pkg;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_w(input int depth);
    return (depth < 2) ? 1 : $clog2(depth);
  endfunction

  typedef struct packed {
    logic overflow;
    logic underflow;
  } qs_fifo_err_t;

endpackage

// File: rtl/qs_fifo_ptr.sv
// Wrap-around pointer for a FIFO of arbitrary DEPTH (non-power-of-2 allowed).
// Wrap is an explicit compare against DEPTH-1, not binary rollover.
module qs_fifo_ptr
  import qs_fifo_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  output logic [ptr_w(DEPTH)-1:0]  ptr
);

  localparam int PW = ptr_w(DEPTH);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr <= '0;
    end else if (en) begin
      ptr <= (ptr == LAST) ? '0 : ptr + 1'b1;
    end
  end

endmodule

// File: rtl/qs_fifo_flex.sv
// Single-clock show-ahead FIFO with occupancy count and programmable flags.
// Define QS_FIFO_ERR_EN to add sticky overflow/underflow flags with err_clr_i.
module qs_fifo_flex
  import qs_fifo_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int DEPTH     = 4,
  parameter int AFULL_TH  = DEPTH - 1,
  parameter int AEMPTY_TH = 1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push_i,
  input  logic [DATA_W-1:0]        push_data_i,
  input  logic                     pop_i,
  output logic [DATA_W-1:0]        pop_data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic                     almost_full_o,
  output logic                     almost_empty_o,
  output logic [cnt_w(DEPTH)-1:0]  count_o
`ifdef QS_FIFO_ERR_EN
  ,
  input  logic                     err_clr_i,
  output logic                     overflow_o,
  output logic                     underflow_o
`endif
);

  localparam int CW = cnt_w(DEPTH);
  localparam int PW = ptr_w(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic              push_acc;
  logic              pop_acc;

  // A pop frees a slot in the same edge, so a full FIFO can still accept a push.
  assign pop_acc  = pop_i & ~empty_o;
  assign push_acc = push_i & (~full_o | pop_i);

  qs_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (push_acc),
    .ptr     (wr_ptr)
  );

  qs_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (pop_acc),
    .ptr     (rd_ptr)
  );

  always_ff @(posedge clk) begin
    if (push_acc) begin
      mem[wr_ptr] <= push_data_i;
    end
  end

  always_comb begin
    count_next = count_reg;
    if (push_acc && !pop_acc) begin
      count_next = count_reg + 1'b1;
    end else if (pop_acc && !push_acc) begin
      count_next = count_reg - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_reg <= '0;
    end else begin
      count_reg <= count_next;
    end
  end

  // Flags come only from the registered count, never from the request inputs.
  assign count_o        = count_reg;
  assign empty_o        = (count_reg == '0);
  assign full_o         = (count_reg == CW'(DEPTH));
  assign almost_full_o  = (count_reg >= CW'(AFULL_TH));
  assign almost_empty_o = (count_reg <= CW'(AEMPTY_TH));
  assign pop_data_o     = empty_o ? '0 : mem[rd_ptr];

`ifdef QS_FIFO_ERR_EN
  qs_fifo_err_t err_reg;
  qs_fifo_err_t err_next;
  logic         ovf_set;
  logic         unf_set;

  assign ovf_set = push_i & full_o & ~pop_i;
  assign unf_set = pop_i & empty_o;

  // A new error in the clearing cycle must survive the clear.
  always_comb begin
    err_next           = err_reg;
    err_next.overflow  = ovf_set | (err_reg.overflow  & ~err_clr_i);
    err_next.underflow = unf_set | (err_reg.underflow & ~err_clr_i);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_reg <= '0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign overflow_o  = err_reg.overflow;
  assign underflow_o = err_reg.underflow;
`endif

endmodule

// File: tb/tb_qs_fifo_flex.sv
// Self-checking bench for qs_fifo_flex (DEPTH=3) against a queue-based model.
// Error-flag checks are active when QS_FIFO_ERR_EN is defined.
module tb_qs_fifo_flex;

  localparam int DATA_W    = 8;
  localparam int DEPTH     = 3;
  localparam int AFULL_TH  = 2;
  localparam int AEMPTY_TH = 1;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             push_i;
  logic [DATA_W-1:0] push_data_i;
  logic             pop_i;
  logic [DATA_W-1:0] pop_data_o;
  logic             full_o;
  logic             empty_o;
  logic             almost_full_o;
  logic             almost_empty_o;
  logic [1:0]       count_o;
`ifdef QS_FIFO_ERR_EN
  logic             err_clr_i;
  logic             overflow_o;
  logic             underflow_o;
`endif

  int tests_run = 0;
  int tests_failed = 0;

  // Reference model state
  logic [7:0] q[$];
  bit         m_ovf;
  bit         m_unf;

  always #5 clk = ~clk;

  qs_fifo_flex #(
    .DATA_W    (DATA_W),
    .DEPTH     (DEPTH),
    .AFULL_TH  (AFULL_TH),
    .AEMPTY_TH (AEMPTY_TH)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .push_i         (push_i),
    .push_data_i    (push_data_i),
    .pop_i          (pop_i),
    .pop_data_o     (pop_data_o),
    .full_o         (full_o),
    .empty_o        (empty_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o),
    .count_o        (count_o)
`ifdef QS_FIFO_ERR_EN
    ,
    .err_clr_i      (err_clr_i),
    .overflow_o     (overflow_o),
    .underflow_o    (underflow_o)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    int n;
    n = q.size();
    check({tag, ":count"},  32'(count_o),        32'(n));
    check({tag, ":empty"},  32'(empty_o),        32'(n == 0));
    check({tag, ":full"},   32'(full_o),         32'(n == DEPTH));
    check({tag, ":afull"},  32'(almost_full_o),  32'(n >= AFULL_TH));
    check({tag, ":aempty"}, 32'(almost_empty_o), 32'(n <= AEMPTY_TH));
    check({tag, ":data"},   32'(pop_data_o),     (n == 0) ? 32'h0 : 32'(q[0]));
`ifdef QS_FIFO_ERR_EN
    check({tag, ":ovf"},    32'(overflow_o),     32'(m_ovf));
    check({tag, ":unf"},    32'(underflow_o),    32'(m_unf));
`endif
  endtask

  // One clock cycle: drive at negedge, update model at posedge, check at next negedge.
  task automatic step(input string tag, input bit push, input bit pop,
                      input logic [7:0] data, input bit clr);
    bit full_m, empty_m, push_acc, pop_acc, ovf_set, unf_set;
    int n_before;
    push_i      = push;
    pop_i       = pop;
    push_data_i = data;
`ifdef QS_FIFO_ERR_EN
    err_clr_i   = clr;
`endif
    n_before = q.size();
    #1;
    check({tag, ":nocomb"}, 32'(count_o), 32'(n_before));
    @(posedge clk);
    full_m   = (q.size() == DEPTH);
    empty_m  = (q.size() == 0);
    pop_acc  = pop && !empty_m;
    push_acc = push && (!full_m || pop);
    ovf_set  = push && full_m && !pop;
    unf_set  = pop && empty_m;
    m_ovf    = ovf_set || (m_ovf && !clr);
    m_unf    = unf_set || (m_unf && !clr);
    if (pop_acc)  void'(q.pop_front());
    if (push_acc) q.push_back(data);
    @(negedge clk);
    push_i = 1'b0;
    pop_i  = 1'b0;
`ifdef QS_FIFO_ERR_EN
    err_clr_i = 1'b0;
`endif
    check_all(tag);
  endtask

  initial begin
    reset_n     = 1'b0;
    push_i      = 1'b0;
    pop_i       = 1'b0;
    push_data_i = '0;
`ifdef QS_FIFO_ERR_EN
    err_clr_i   = 1'b0;
`endif
    m_ovf = 0;
    m_unf = 0;
    #1;
    check_all("in_reset");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    step("idle", 0, 0, 8'h00, 0);

    // Asynchronous reset from count=2, no clock edge in between
    step("pre_rst_a", 1, 0, 8'hAB, 0);
    step("pre_rst_b", 1, 1, 8'hCC, 0);
    step("pre_rst_c", 1, 0, 8'h5A, 0);
    check("pre_rst_count", 32'(count_o), 32'd2);
    #2;
    reset_n = 1'b0;
    #1;
    q.delete();
    m_ovf = 0;
    m_unf = 0;
    check_all("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    check_all("post_rst");

    // Fill
    step("push_ab", 1, 0, 8'hAB, 0);
    check("head_ab", 32'(pop_data_o), 32'hAB);
    step("push_cc", 1, 0, 8'hCC, 0);
    check("afull_at2", 32'(almost_full_o), 32'd1);
    step("push_dd", 1, 0, 8'hDD, 0);
    check("full_at3", 32'(full_o), 32'd1);

    // Full with push+pop, then dropped push
    step("full_pp", 1, 1, 8'hEE, 0);
    check("head_cc", 32'(pop_data_o), 32'hCC);
    step("drop_11", 1, 0, 8'h11, 0);

    // Drain and underflow
    step("pop1", 0, 1, 8'h00, 0);
    step("pop2", 0, 1, 8'h00, 0);
    step("pop3", 0, 1, 8'h00, 0);
    step("pop4_empty", 0, 1, 8'h00, 0);
    step("err_clr", 0, 0, 8'h00, 1);

    // Wrap stress: push then pop, data 1..10
    for (int i = 1; i <= 10; i++) begin
      step("wrap_push", 1, 0, 8'(i), 0);
      check("wrap_head", 32'(pop_data_o), 32'(i));
      step("wrap_pop", 0, 1, 8'h00, 0);
    end

    // Push+pop while empty
    step("empty_pp", 1, 1, 8'hAA, 0);
    check("empty_pp_head", 32'(pop_data_o), 32'hAA);
    step("clr2", 0, 1, 8'h00, 1);

    // Random traffic, including set-vs-clear collisions
    for (int i = 0; i < 300; i++) begin
      step("rand", 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
           8'($urandom), ($urandom_range(0, 9) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/qs_fifo_flex.md
Name: qs_fifo_flex

Overview:
- Parametrised next-generation synchronous single-clock FIFO for the qs datapath.
- Supports any DEPTH ≥ 2, including non-power-of-2, with wrap-around pointers.
- Adds an occupancy count, programmable almost-full/almost-empty flags and push/pop in the same cycle when full.
- Read data is show-ahead: the head entry is always visible on pop_data_o.

Parameters:
- DATA_W, 8, width of each data entry.
- DEPTH, 4, number of entries; legal range ≥ 2, any integer.
- AFULL_TH, DEPTH-1, almost_full_o asserts when count ≥ AFULL_TH; legal range 1..DEPTH.
- AEMPTY_TH, 1, almost_empty_o asserts when count ≤ AEMPTY_TH; legal range 0..DEPTH-1.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- push_i  in  1  write request.
- push_data_i  in  DATA_W  write data.
- pop_i  in  1  read request; consumes the head entry.
- pop_data_o  out  DATA_W  head entry (show-ahead); reads 0 when empty.
- full_o  out  1  count == DEPTH.
- empty_o  out  1  count == 0.
- almost_full_o  out  1  count ≥ AFULL_TH.
- almost_empty_o  out  1  count ≤ AEMPTY_TH.
- count_o  out  $clog2(DEPTH+1)  current occupancy.

Behaviour:
- Reset (reset_n low, asynchronous assert, synchronous-release usage): wr_ptr=0, rd_ptr=0, count=0.
  - Outputs during reset: empty_o=1, full_o=0, almost_empty_o=1, almost_full_o=0, pop_data_o=0.
  - Memory contents are not reset.
- Accept rules:
  - pop_acc = pop_i & !empty_o.
  - push_acc = push_i & (!full_o | pop_i).
- Push while full with pop_i=1: both accepted; count stays DEPTH.
- Push while empty with pop_i=1: push accepted, pop ignored. count becomes 1 and the new data appears on pop_data_o the next cycle. No combinational write-to-read bypass.
- Push while full without pop: dropped; state unchanged.
- Pop while empty: ignored; state unchanged.
- Write: on push_acc, mem[wr_ptr] <= push_data_i and wr_ptr advances.
- Read: on pop_acc, rd_ptr advances. pop_data_o = empty_o ? 0 : mem[rd_ptr] (combinational from registered state).
- Pointer wrap: when ptr == DEPTH-1, next value is 0 (explicit compare, not modulo-2^n).
- Count update: count_next = count + push_acc - pop_acc; never exceeds DEPTH, never underflows.
- Flag timing: all flags and count_o derive from registered count, so they update the cycle after the accepting edge. No combinational path from push_i/pop_i to any flag.
- Latency: write to pop_data_o visible is 1 cycle.

Optional Feature:
- Macro: QS_FIFO_ERR_EN.
- When defined, the block adds:
  - input err_clr_i [1].
  - output overflow_o [1]: sticky; set on push_i & full_o & !pop_i.
  - output underflow_o [1]: sticky; set on pop_i & empty_o.
- Sticky flag rules: cleared by err_clr_i; if set and clear occur in the same cycle, set wins. Reset value is 0.
- When undefined: these ports and registers do not exist. Dropped requests are silently ignored; everything else is identical.

Decomposition:
- Package qs_fifo_pkg holds:
  - function cnt_w(depth), returning $clog2(depth+1).
  - function ptr_w(depth), returning max(1, $clog2(depth)).
  - typedef for the per-instance error-status struct {overflow, underflow}.
- Sub-module qs_fifo_ptr (parameter DEPTH): wrap-around pointer with enable. Instantiated twice, for wr_ptr and rd_ptr.

Test Plan (DATA_W=8, DEPTH=3, AFULL_TH=2, AEMPTY_TH=1):
- Reset then idle -> empty_o=1, almost_empty_o=1, full_o=0, count_o=0, pop_data_o=0. Assert reset_n low mid-operation with count=2 -> all outputs return to reset values immediately, without waiting for a clock.
- Push AB, CC, DD on consecutive cycles -> count_o 1,2,3; almost_full_o rises at count 2; full_o=1 after 3rd push; pop_data_o=AB from the cycle after the 1st push.
- From full, push EE with pop_i=1 -> AB popped, EE stored, count stays 3, pop_data_o=CC. Then push 11 without pop -> dropped; overflow_o=1 (ERR_EN).
- Pop 3 times -> pop_data_o CC, DD, EE, then 0; empty_o=1. A 4th pop -> ignored; underflow_o=1 (ERR_EN). err_clr_i pulse -> both error flags 0.
- Wrap stress: 10 interleaved push/pop pairs with data 0x01..0x0A -> pop order matches push order across ≥3 pointer wraps; count never exceeds 3.
- Push AA with pop_i=1 while empty -> count_o=1 next cycle, pop_data_o=AA, no underflow-induced state change; underflow_o=1 only if ERR_EN is defined.
